// File: rtl/pattern_match_ctrl_pkg.sv
// Shared definitions for the pattern-detector sequencer.
//   - pm_state_e : controller states, encodings kept from the legacy design
//   - PM_W/PM_CW : default pattern width and detect-counter width
//   - cnt_w()    : width of a counter that must hold the value w
package pattern_match_ctrl_pkg;

  localparam int unsigned PM_W  = 4;
  localparam int unsigned PM_CW = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    FILL  = 3'd3,
    RUN   = 3'd4
  } pm_state_e;

  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/pattern_match_ctrl_serializer.sv
// pattern_serializer: holds the accepted pattern and streams it MSB-first
// into the program SIPO while the controller sits in LOAD.
//   clk, clr      : clock, synchronous active-low reset
//   load          : capture pattern into the shadow register
//   restart       : zero the bit index (controller is in CLEAR)
//   active        : controller is in LOAD; shift one bit out per cycle
//   pattern       : parallel pattern, bit W-1 leaves first
//   prgm_out      : serial data to the program SIPO (0 when idle)
//   prgm_shift_en : program SIPO shift enable
//   done          : last bit is being shifted this cycle
module pattern_serializer
  import pattern_match_ctrl_pkg::*;
#(
  parameter int unsigned W = PM_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         restart,
  input  logic         active,
  input  logic [W-1:0] pattern,
  output logic         prgm_out,
  output logic         prgm_shift_en,
  output logic         done
);

  localparam int unsigned IW = cnt_w(W);

  logic [W-1:0]  shadow_q;
  logic [IW-1:0] idx_q;

  // The shadow is shifted left as bits go out, so its MSB is always
  // shadow[W-1-k] of the captured pattern for load cycle k.
  always_ff @(posedge clk) begin
    if (!clr) begin
      shadow_q <= '0;
      idx_q    <= '0;
    end else begin
      if (load)
        shadow_q <= pattern;
      else if (active)
        shadow_q <= shadow_q << 1;

      if (restart)
        idx_q <= '0;
      else if (active)
        idx_q <= idx_q + 1'b1;
    end
  end

  assign prgm_shift_en = active;
  assign prgm_out      = active & shadow_q[W-1];
  assign done          = active && (idx_q == IW'(W - 1));

endmodule

// File: rtl/pattern_match_ctrl.sv
// pattern_match_ctrl: sequencer for the serial pattern detector.
// Accepts a pattern over cfg_valid/cfg_ready, clears the datapath, loads the
// program SIPO, then gates the signal stream into the signal SIPO and turns
// the comparator result into detect pulses and a saturating count.
//   clk, clr                  : clock, synchronous active-low reset
//   cfg_valid/ready/pattern   : pattern handshake
//   sig_valid/bit/ready       : serial signal handshake
//   prgm_out, prgm_shift_en   : program SIPO drive
//   sig_out, sig_shift_en     : signal SIPO drive
//   dp_clr_n                  : active-low clear to both SIPOs
//   eq_in                     : comparator result
//   detect                    : one-cycle match pulse
//   detect_count, count_sat   : saturating detect count and sticky flag
//   busy                      : in CLEAR or LOAD
module pattern_match_ctrl
  import pattern_match_ctrl_pkg::*;
#(
  parameter int unsigned W  = PM_W,
  parameter int unsigned CW = PM_CW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_pattern,
  input  logic          sig_valid,
  input  logic          sig_bit,
  output logic          sig_ready,
  output logic          prgm_out,
  output logic          prgm_shift_en,
  output logic          sig_out,
  output logic          sig_shift_en,
  output logic          dp_clr_n,
  input  logic          eq_in,
  output logic          detect,
  output logic [CW-1:0] detect_count,
  output logic          count_sat,
  output logic          busy
);

  localparam int unsigned FCW = cnt_w(W);

  pm_state_e      state_q, state_d;
  logic [FCW-1:0] fill_cnt_q;
  logic           shifted_q;
  logic           cfg_fire, accept, load_done, detect_d;
  logic [CW-1:0]  count_inc;

  assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
  assign cfg_fire  = cfg_valid && cfg_ready;
  // A pending configuration always wins over a signal bit.
  assign sig_ready = ((state_q == FILL) || (state_q == RUN)) && !cfg_valid;
  assign accept    = sig_valid && sig_ready;

  assign sig_shift_en = accept;
  assign sig_out      = accept & sig_bit;
  assign dp_clr_n     = (state_q != CLEAR);
  assign busy         = (state_q == CLEAR) || (state_q == LOAD);

  pattern_serializer #(
    .W (W)
  ) u_ser (
    .clk           (clk),
    .clr           (clr),
    .load          (cfg_fire),
    .restart       (state_q == CLEAR),
    .active        (state_q == LOAD),
    .pattern       (cfg_pattern),
    .prgm_out      (prgm_out),
    .prgm_shift_en (prgm_shift_en),
    .done          (load_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_fire) state_d = CLEAR;
      CLEAR:   state_d = LOAD;
      LOAD:    if (load_done) state_d = FILL;
      FILL:    if (accept && (fill_cnt_q == FCW'(W - 1))) state_d = RUN;
      RUN:     if (cfg_fire) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // A compare left pending by the previous accept is dropped when a new
  // configuration is taken in the same cycle.
  assign detect_d  = shifted_q && eq_in && (state_q == RUN) && !cfg_fire;
  assign count_inc = detect_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= IDLE;
      fill_cnt_q   <= '0;
      shifted_q    <= 1'b0;
      detect       <= 1'b0;
      detect_count <= '0;
      count_sat    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shifted_q <= accept;
      detect    <= detect_d;
      if (state_q == CLEAR) begin
        fill_cnt_q   <= '0;
        detect_count <= '0;
        count_sat    <= 1'b0;
      end else begin
        if ((state_q == FILL) && accept)
          fill_cnt_q <= fill_cnt_q + 1'b1;
        if (detect_d && !(&detect_count)) begin
          detect_count <= count_inc;
          if (&count_inc)
            count_sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Directed bench for pattern_match_ctrl with a behavioural SIPO/comparator
// datapath around it. Counter width is overridden to 2 to reach saturation.
module tb_pattern_match_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          clr;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_pattern;
  logic          sig_valid;
  logic          sig_bit;
  logic          sig_ready;
  logic          prgm_out;
  logic          prgm_shift_en;
  logic          sig_out;
  logic          sig_shift_en;
  logic          dp_clr_n;
  logic          eq_in;
  logic          detect;
  logic [CW-1:0] detect_count;
  logic          count_sat;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_log[$];
  int det_log[$];

  logic [W-1:0] prog_r, sig_r;

  always #5 clk = ~clk;

  pattern_match_ctrl #(
    .W  (W),
    .CW (CW)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_pattern   (cfg_pattern),
    .sig_valid     (sig_valid),
    .sig_bit       (sig_bit),
    .sig_ready     (sig_ready),
    .prgm_out      (prgm_out),
    .prgm_shift_en (prgm_shift_en),
    .sig_out       (sig_out),
    .sig_shift_en  (sig_shift_en),
    .dp_clr_n      (dp_clr_n),
    .eq_in         (eq_in),
    .detect        (detect),
    .detect_count  (detect_count),
    .count_sat     (count_sat),
    .busy          (busy)
  );

  // Behavioural datapath: two SIPOs shifting in at the LSB and a comparator.
  always @(posedge clk) begin
    if (!clr || !dp_clr_n) begin
      prog_r <= '0;
      sig_r  <= '0;
    end else begin
      if (prgm_shift_en) prog_r <= {prog_r[W-2:0], prgm_out};
      if (sig_shift_en)  sig_r  <= {sig_r[W-2:0], sig_out};
    end
  end
  assign eq_in = (prog_r == sig_r);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (detect) det_log.push_back(cyc);
    chk("shift_without_valid", {31'd0, sig_shift_en & ~sig_valid}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern(input logic [W-1:0] p);
    cfg_valid   = 1'b1;
    cfg_pattern = p;
    #1;
    chk("cfg_ready_accept", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    #1;
    chk("clear_dp_clr_n", dp_clr_n, 0);
    chk("clear_busy", busy, 1);
    chk("clear_cfg_ready", cfg_ready, 0);
    chk("clear_sig_ready", sig_ready, 0);
    tick();
    for (int k = 0; k < W; k++) begin
      #1;
      chk("load_shift_en", prgm_shift_en, 1);
      chk("load_prgm_out", prgm_out, p[W-1-k]);
      chk("load_dp_clr_n", dp_clr_n, 1);
      chk("load_busy", busy, 1);
      chk("load_sig_ready", sig_ready, 0);
      if (k == 0) begin
        chk("load_count_cleared", detect_count, 0);
        chk("load_sat_cleared", count_sat, 0);
      end
      tick();
    end
    #1;
    chk("fill_shift_en_off", prgm_shift_en, 0);
    chk("fill_busy", busy, 0);
    chk("fill_sig_ready", sig_ready, 1);
  endtask

  task automatic send_bit(input logic b);
    sig_valid = 1'b1;
    sig_bit   = b;
    #1;
    chk("send_sig_ready", sig_ready, 1);
    chk("send_shift_en", sig_shift_en, 1);
    chk("send_sig_out", sig_out, b);
    acc_log.push_back(cyc);
    tick();
    sig_valid = 1'b0;
  endtask

  task automatic gap();
    sig_valid = 1'b0;
    #1;
    chk("gap_shift_en", sig_shift_en, 0);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] stream;
    stream = 7'b1011011;

    clr = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; sig_valid = 1'b0; sig_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_detect", detect, 0);
    chk("rst_count", detect_count, 0);
    chk("rst_sat", count_sat, 0);
    chk("rst_dp_clr_n", dp_clr_n, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_sig_ready", sig_ready, 0);
    chk("rst_prgm_shift_en", prgm_shift_en, 0);
    chk("rst_prgm_out", prgm_out, 0);
    clr = 1'b1;
    #1;
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_sig_ready", sig_ready, 0);
    tick();

    // Back-to-back stream against 1011: matches at accepts 4 and 7.
    load_pattern(4'b1011);
    acc_log.delete(); det_log.delete();
    for (int i = 0; i < 7; i++) send_bit(stream[6-i]);
    repeat (3) gap();
    chk("b2b_det_num", det_log.size(), 2);
    if (det_log.size() == 2 && acc_log.size() == 7) begin
      chk("b2b_det0_time", det_log[0], acc_log[3] + 2);
      chk("b2b_det1_time", det_log[1], acc_log[6] + 2);
    end
    chk("b2b_count", detect_count, 2);
    chk("b2b_sat", count_sat, 0);

    // Same stream with a gap after every bit; reprogram from RUN.
    load_pattern(4'b1011);
    acc_log.delete(); det_log.delete();
    for (int i = 0; i < 7; i++) begin
      send_bit(stream[6-i]);
      gap();
    end
    repeat (2) gap();
    chk("gap_det_num", det_log.size(), 2);
    if (det_log.size() == 2 && acc_log.size() == 7) begin
      chk("gap_det0_time", det_log[0], acc_log[3] + 2);
      chk("gap_det1_time", det_log[1], acc_log[6] + 2);
    end
    chk("gap_count", detect_count, 2);

    // All-zero pattern, eight zeros: five detects, count saturates at 3.
    load_pattern(4'b0000);
    acc_log.delete(); det_log.delete();
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    repeat (3) gap();
    chk("sat_det_num", det_log.size(), 5);
    if (det_log.size() == 5 && acc_log.size() == 8) begin
      chk("sat_det_first", det_log[0], acc_log[3] + 2);
      chk("sat_det_last", det_log[4], acc_log[7] + 2);
    end
    chk("sat_count", detect_count, 3);
    chk("sat_flag", count_sat, 1);

    // Reprogram clears the count; then a config collides with a matching bit.
    load_pattern(4'b1011);
    acc_log.delete(); det_log.delete();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    sig_valid = 1'b1; sig_bit = 1'b1; cfg_valid = 1'b1; cfg_pattern = 4'b0110;
    #1;
    chk("race_sig_ready", sig_ready, 0);
    chk("race_shift_en", sig_shift_en, 0);
    chk("race_cfg_ready", cfg_ready, 1);
    tick();
    sig_valid = 1'b0; cfg_valid = 1'b0;
    #1;
    chk("race_clear", dp_clr_n, 0);
    chk("race_detect", detect, 0);
    tick();
    #1;
    chk("race_load0_shift_en", prgm_shift_en, 1);
    chk("race_load0_prgm_out", prgm_out, 0);
    chk("race_load0_detect", detect, 0);
    chk("race_load0_count", detect_count, 0);
    tick();
    chk("race_det_num", det_log.size(), 1);

    // Reset during the second LOAD cycle aborts the load.
    clr = 1'b0;
    #1;
    chk("abort_prgm_out", prgm_out, 1);
    tick();
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("abort_shift_en", prgm_shift_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_cfg_ready", cfg_ready, 1);
      chk("abort_dp_clr_n", dp_clr_n, 1);
      tick();
    end
    chk("abort_count", detect_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_match_ctrl.md
Name: pattern_match_ctrl

Overview:
- Sequencer for the serial pattern-detector datapath: two shift-enabled SIPO registers (program, signal) feeding an equality comparator.
- Accepts a parallel pattern over a valid/ready handshake, clears the datapath, then serializes the pattern into the program register MSB-first.
- Gates the incoming signal bit stream into the signal register and qualifies the comparator output into single-cycle detect pulses plus a saturating detect counter.

Parameters:
- W, 4, pattern width; equals the depth of both SIPO registers.
- CW, 8, width of detect_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  synchronous active-low reset.
- cfg_valid  in  1  new pattern offered.
- cfg_ready  out  1  pattern can be accepted.
- cfg_pattern  in  W  pattern; bit W-1 is shifted first.
- sig_valid  in  1  sig_bit is valid this cycle.
- sig_bit  in  1  serial signal input.
- sig_ready  out  1  controller accepts sig_bit this cycle.
- prgm_out  out  1  serial data to the program SIPO.
- prgm_shift_en  out  1  program SIPO shift enable.
- sig_out  out  1  serial data to the signal SIPO.
- sig_shift_en  out  1  signal SIPO shift enable.
- dp_clr_n  out  1  synchronous active-low clear to both SIPOs.
- eq_in  in  1  comparator equality result (combinational from the SIPO contents).
- detect  out  1  one-cycle match pulse.
- detect_count  out  CW  number of detects since the last configuration, saturating.
- count_sat  out  1  sticky; detect_count has saturated.
- busy  out  1  high in CLEAR or LOAD.

Behaviour:
- Reset: clr=0 at an edge forces state IDLE and clears all counters, shadow pattern, shifted_q, detect, detect_count and count_sat.
  - Reset values: dp_clr_n=1, prgm_shift_en=0, sig_shift_en=0, prgm_out=0, sig_out=0, busy=0.
  - A reset mid-operation (any state) has the same effect; no partial load completes.
- FSM states: IDLE, CLEAR, LOAD, FILL, RUN.
- IDLE:
  - cfg_ready=1, sig_ready=0.
  - On cfg_valid&&cfg_ready: latch cfg_pattern into the shadow register, go to CLEAR.
- CLEAR: exactly 1 cycle.
  - dp_clr_n=0.
  - Clear detect_count, count_sat, fill and bit counters, shifted_q.
  - Go to LOAD.
- LOAD: exactly W cycles.
  - prgm_shift_en=1, prgm_out=shadow[W-1-k] for k=0..W-1.
  - cfg_ready=0, sig_ready=0.
  - After cycle k=W-1, go to FILL.
- FILL:
  - sig_ready=1 unless cfg_valid (see below).
  - Each accept (sig_valid&&sig_ready): sig_shift_en=1, sig_out=sig_bit, fill_cnt++.
  - On the W-th accept, go to RUN.
  - Gaps (sig_valid=0) stall without side effects.
- RUN:
  - Same accept rule as FILL, no counting.
  - cfg_ready=1 in RUN.
- shifted_q: set on the cycle after any accept, else 0.
- detect (registered) = shifted_q && eq_in && state==RUN.
  - The bit accepted in cycle N yields detect in cycle N+2.
  - The W-th fill accept produces the first valid compare.
- Shift enables and serial data outputs are combinational from state/handshake; detect and the counters are registered.
- detect_count:
  - Increments on each detect.
  - At 2^CW-1 it holds, and count_sat sets and stays set until CLEAR or reset.
- Reprogram:
  - cfg_valid&&cfg_ready in RUN goes to CLEAR.
  - sig_ready = (FILL||RUN) && !cfg_valid, so a simultaneous sig bit is not accepted; configuration wins.
  - A pending shifted_q is discarded, so no detect is issued for it.
- cfg_valid during FILL: not accepted (cfg_ready=0), but still suppresses sig_ready.
- W=1: LOAD lasts 1 cycle; FILL goes to RUN on the first accept.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, LOAD, FILL, RUN), default W=4, default CW=8, counter width helper $clog2(W+1).
- One sub-module, pattern_serializer: shadow register plus bit index, drives prgm_out/prgm_shift_en and signals done. FSM, handshake and detect/count logic stay in pattern_match_ctrl.

Test Plan:
- Reset check: hold clr=0 for 3 cycles -> busy=0, detect=0, detect_count=0, dp_clr_n=1, cfg_ready=1, sig_ready=0.
- Load 4'b1011 via cfg handshake -> next cycle dp_clr_n=0 for exactly 1 cycle, busy=1 -> then 4 cycles prgm_shift_en=1 with prgm_out 1,0,1,1 -> then sig_ready=1, busy=0.
- Stream 1,0,1,1,0,1,1 back-to-back with a behavioral SIPO+comparator model -> exactly 2 detect pulses, each 2 cycles after the 4th and 7th accepts; detect_count=2.
- Same stream with sig_valid toggling 1/0 -> same 2 detects, each at accept+2; sig_shift_en never high when sig_valid=0.
- CW=2, pattern 4'b0000, stream of 8 zeros -> detects on accepts 4..8, detect_count stops at 3, count_sat=1; reprogram -> count 0, count_sat=0.
- In RUN, assert cfg_valid with sig_valid in the same cycle as a match-completing bit -> bit not accepted, no detect, CLEAR next cycle.
- Separately, clr=0 during LOAD cycle 2 -> IDLE, no further prgm_shift_en.
